// File: rtl/hc_csr_bank_if.sv
// MMIO request/response bundle between the CCI-P shim and hc_csr_bank.
// addr is the header word address (byte offset >> 2).
interface hc_csr_bank_if;
  logic        mmio_wr_valid;
  logic        mmio_rd_valid;
  logic [15:0] addr;
  logic [8:0]  tid;
  logic [63:0] data;
  logic        rsp_valid;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data;

  modport master (
    output mmio_wr_valid, mmio_rd_valid, addr, tid, data,
    input  rsp_valid, rsp_tid, rsp_data
  );

  modport slave (
    input  mmio_wr_valid, mmio_rd_valid, addr, tid, data,
    output rsp_valid, rsp_tid, rsp_data
  );
endinterface

// File: rtl/hc_csr_bank.sv
// HardCloud MMIO register bank: DSM base, control, buffer descriptors and start/stop FSM.
// Define HC_CSR_READBACK_EN to make every mapped register readable; otherwise only status reads back.
module hc_csr_bank #(
  parameter int          NUM_BUFFERS = 2,
  parameter logic [15:0] BUF_BASE    = 16'h120,
  parameter logic [15:0] DSM_ADDR    = 16'h110,
  parameter logic [15:0] CTL_ADDR    = 16'h118,
  parameter logic [15:0] STS_ADDR    = 16'h100
) (
  input  logic                clk,
  input  logic                reset,
  hc_csr_bank_if.slave        mmio,
  output logic [63:0]         dsm_base,
  output logic [63:0]         buf_addr [NUM_BUFFERS],
  output logic [31:0]         buf_size [NUM_BUFFERS],
  output logic                acc_reset,
  output logic                acc_start,
  input  logic                acc_done,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_READY = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_STOP  = 3'd4
  } state_e;

  localparam logic [17:0] BUF_B    = {2'b00, BUF_BASE};
  localparam logic [17:0] DSM_B    = {2'b00, DSM_ADDR};
  localparam logic [17:0] CTL_B    = {2'b00, CTL_ADDR};
  localparam logic [17:0] STS_B    = {2'b00, STS_ADDR};
  localparam logic [17:0] BUF_SPAN = 18'(16 * NUM_BUFFERS);

  state_e      state_q, state_d;
  logic        done_sticky_q, done_sticky_d;
  logic        acc_start_q, acc_start_d;
  logic [63:0] dsm_base_q, dsm_base_d;
  logic [63:0] buf_addr_q [NUM_BUFFERS];
  logic [63:0] buf_addr_d [NUM_BUFFERS];
  logic [31:0] buf_size_q [NUM_BUFFERS];
  logic [31:0] buf_size_d [NUM_BUFFERS];
  logic        rsp_valid_q, rsp_valid_d;
  logic [8:0]  rsp_tid_q, rsp_tid_d;
  logic [63:0] rsp_data_q, rsp_data_d;

  logic [17:0] byte_off;
  logic [17:0] buf_off;
  logic [3:0]  buf_idx;
  logic        decoded;
  logic        in_buf;
  logic        hit_dsm, hit_ctl, hit_sts, hit_buf_addr, hit_buf_size;
  logic        ctl_wr;

  // Only the upper CSR window (byte offset >= 0x100) is decoded at all.
  assign byte_off     = {mmio.addr, 2'b00};
  assign decoded      = byte_off >= 18'h100;
  assign buf_off      = byte_off - BUF_B;
  assign in_buf       = decoded && (byte_off >= BUF_B) && (buf_off < BUF_SPAN);
  assign buf_idx      = buf_off[7:4];
  assign hit_buf_addr = in_buf && (buf_off[3:0] == 4'h0);
  assign hit_buf_size = in_buf && (buf_off[3:0] == 4'h8);
  assign hit_dsm      = decoded && (byte_off == DSM_B);
  assign hit_ctl      = decoded && (byte_off == CTL_B);
  assign hit_sts      = decoded && (byte_off == STS_B);
  assign ctl_wr       = mmio.mmio_wr_valid && hit_ctl;

  always_comb begin
    dsm_base_d = dsm_base_q;
    buf_addr_d = buf_addr_q;
    buf_size_d = buf_size_q;
    if (mmio.mmio_wr_valid) begin
      if (hit_dsm) dsm_base_d = mmio.data;
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        if (buf_idx == 4'(i)) begin
          if (hit_buf_addr) buf_addr_d[i] = mmio.data;
          if (hit_buf_size) buf_size_d[i] = mmio.data[31:0];
        end
      end
    end
  end

  // A CTL write takes priority over acc_done in the same cycle.
  always_comb begin
    state_d       = state_q;
    done_sticky_d = done_sticky_q;
    acc_start_d   = 1'b0;
    if (ctl_wr) begin
      case (mmio.data[31:0])
        32'h0: state_d = S_RESET;
        32'h1: if (state_q inside {S_RESET, S_DONE, S_STOP}) state_d = S_READY;
        32'h3: if (state_q == S_READY) begin
          state_d     = S_RUN;
          acc_start_d = 1'b1;
        end
        32'h7: if (state_q inside {S_RUN, S_DONE}) begin
          state_d = S_STOP;
          if (state_q == S_RUN && acc_done) done_sticky_d = 1'b1;
        end
        default: ;
      endcase
    end else if (acc_done && state_q == S_RUN) begin
      state_d       = S_DONE;
      done_sticky_d = 1'b1;
    end
    if (state_d == S_RESET || (state_d == S_RUN && state_q != S_RUN)) done_sticky_d = 1'b0;
  end

`ifdef HC_CSR_READBACK_EN
  logic [31:0] ctl_q, ctl_d;

  always_comb begin
    ctl_d = ctl_q;
    if (ctl_wr) ctl_d = mmio.data[31:0];
  end

  always_ff @(posedge clk) begin
    if (reset) ctl_q <= '0;
    else       ctl_q <= ctl_d;
  end
`endif

  // Read data is muxed from pre-write register values, so a same-cycle write is not seen.
  always_comb begin
    rsp_valid_d = mmio.mmio_rd_valid;
    rsp_tid_d   = mmio.tid;
    rsp_data_d  = 64'h0;
    if (hit_sts) rsp_data_d = {60'h0, done_sticky_q, state_q};
`ifdef HC_CSR_READBACK_EN
    if (hit_dsm) rsp_data_d = dsm_base_q;
    if (hit_ctl) rsp_data_d = {32'h0, ctl_q};
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      if (buf_idx == 4'(i)) begin
        if (hit_buf_addr) rsp_data_d = buf_addr_q[i];
        if (hit_buf_size) rsp_data_d = {32'h0, buf_size_q[i]};
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_RESET;
      done_sticky_q <= 1'b0;
      acc_start_q   <= 1'b0;
      dsm_base_q    <= '0;
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        buf_addr_q[i] <= '0;
        buf_size_q[i] <= '0;
      end
      rsp_valid_q   <= 1'b0;
      rsp_tid_q     <= '0;
      rsp_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      done_sticky_q <= done_sticky_d;
      acc_start_q   <= acc_start_d;
      dsm_base_q    <= dsm_base_d;
      buf_addr_q    <= buf_addr_d;
      buf_size_q    <= buf_size_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_tid_q     <= rsp_tid_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

  assign mmio.rsp_valid = rsp_valid_q;
  assign mmio.rsp_tid   = rsp_tid_q;
  assign mmio.rsp_data  = rsp_data_q;
  assign dsm_base       = dsm_base_q;
  assign buf_addr       = buf_addr_q;
  assign buf_size       = buf_size_q;
  assign acc_reset      = (state_q == S_RESET);
  assign acc_start      = acc_start_q;
  assign state          = state_q;

endmodule

// File: tb/tb_hc_csr_bank.sv
// Testbench for hc_csr_bank: directed vector table followed by randomized traffic
// checked against a register-map reference model.
`timescale 1ns/1ps
module tb_hc_csr_bank;
  localparam int NB = 4;
`ifdef HC_CSR_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        acc_done;
  logic [63:0] dsm_base;
  logic [63:0] buf_addr [NB];
  logic [31:0] buf_size [NB];
  logic        acc_reset;
  logic        acc_start;
  logic [2:0]  state;

  hc_csr_bank_if mmio_if ();

  hc_csr_bank #(.NUM_BUFFERS(NB)) dut (
    .clk       (clk),
    .reset     (reset),
    .mmio      (mmio_if),
    .dsm_base  (dsm_base),
    .buf_addr  (buf_addr),
    .buf_size  (buf_size),
    .acc_reset (acc_reset),
    .acc_start (acc_start),
    .acc_done  (acc_done),
    .state     (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit prev_start = 1'b0;

  // Reference model: register map keyed by byte offset, FSM as plain integers.
  logic [63:0] m_regs [int];
  bit          m_is32 [int];
  int          m_state;
  bit          m_sticky;
  bit          m_start;
  bit          m_rv;
  logic [8:0]  m_tid;
  logic [63:0] m_rdata;

  function automatic void modelReset();
    m_regs.delete();
    m_is32.delete();
    m_regs['h110] = 64'h0; m_is32['h110] = 1'b0;
    m_regs['h118] = 64'h0; m_is32['h118] = 1'b1;
    for (int i = 0; i < NB; i++) begin
      m_regs['h120 + 16*i] = 64'h0; m_is32['h120 + 16*i] = 1'b0;
      m_regs['h128 + 16*i] = 64'h0; m_is32['h128 + 16*i] = 1'b1;
    end
    m_state  = 0;
    m_sticky = 1'b0;
    m_start  = 1'b0;
    m_rv     = 1'b0;
    m_tid    = '0;
    m_rdata  = '0;
  endfunction

  function automatic logic [63:0] modelRead(int b);
    if (b < 'h100) return 64'h0;
    if (b == 'h100) return 64'(m_sticky * 8 + m_state);
    if (RB && m_regs.exists(b)) return m_regs[b];
    return 64'h0;
  endfunction

  function automatic void modelStep(bit wr, bit rd, int b, logic [8:0] tid, logic [63:0] d,
                                    bit done, bit rst);
    int ns;
    bit ctl_wr;
    if (rst) begin
      modelReset();
      return;
    end
    m_rv    = rd;
    m_tid   = tid;
    m_rdata = modelRead(b);
    ns      = m_state;
    m_start = 1'b0;
    ctl_wr  = wr && (b == 'h118);
    if (ctl_wr) begin
      case (d[31:0])
        32'h0: ns = 0;
        32'h1: if (m_state == 0 || m_state == 3 || m_state == 4) ns = 1;
        32'h3: if (m_state == 1) begin ns = 2; m_start = 1'b1; end
        32'h7: if (m_state == 2 || m_state == 3) begin
          ns = 4;
          if (m_state == 2 && done) m_sticky = 1'b1;
        end
        default: ;
      endcase
    end else if (done && m_state == 2) begin
      ns = 3;
      m_sticky = 1'b1;
    end
    if (ns != m_state && (ns == 0 || ns == 2)) m_sticky = 1'b0;
    m_state = ns;
    if (wr && b >= 'h100 && m_regs.exists(b))
      m_regs[b] = m_is32[b] ? {32'h0, d[31:0]} : d;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic applyStimulus(input bit wr, input bit rd, input logic [15:0] b,
                               input logic [8:0] tid, input logic [63:0] d,
                               input bit done, input bit rst);
    mmio_if.mmio_wr_valid = wr;
    mmio_if.mmio_rd_valid = rd;
    mmio_if.addr          = {2'b00, b[15:2]};
    mmio_if.tid           = tid;
    mmio_if.data          = d;
    acc_done              = done;
    reset                 = rst;
    @(posedge clk);
    #1;
    modelStep(wr, rd, int'(b), tid, d, done, rst);
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, "_dsm"}, dsm_base, m_regs['h110]);
    for (int i = 0; i < NB; i++) begin
      checkOutput($sformatf("%s_baddr%0d", tag, i), buf_addr[i], m_regs['h120 + 16*i]);
      checkOutput($sformatf("%s_bsize%0d", tag, i), 64'(buf_size[i]), m_regs['h128 + 16*i]);
    end
    checkOutput({tag, "_acc_reset"}, 64'(acc_reset), 64'(m_state == 0));
    checkOutput({tag, "_start_twice"}, 64'(prev_start & acc_start), 64'h0);
    prev_start = acc_start;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_state"}, 64'(state), 64'(m_state));
    checkOutput({tag, "_start"}, 64'(acc_start), 64'(m_start));
    checkOutput({tag, "_rsp_valid"}, 64'(mmio_if.rsp_valid), 64'(m_rv));
    if (m_rv) begin
      checkOutput({tag, "_rsp_tid"}, 64'(mmio_if.rsp_tid), 64'(m_tid));
      checkOutput({tag, "_rsp_data"}, mmio_if.rsp_data, m_rdata);
    end
    checkRegs(tag);
  endtask

  typedef struct {
    bit          wr;
    bit          rd;
    logic [15:0] b;
    logic [8:0]  tid;
    logic [63:0] d;
    bit          done;
    bit          rst;
    logic [2:0]  e_state;
    bit          e_start;
    bit          e_rv;
    logic [8:0]  e_tid;
    logic [63:0] e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(bit wr, bit rd, logic [15:0] b, logic [8:0] tid, logic [63:0] d,
                                 bit done, bit rst, logic [2:0] es, bit est, bit erv,
                                 logic [8:0] etid, logic [63:0] edata);
    vec_t v;
    v.wr = wr; v.rd = rd; v.b = b; v.tid = tid; v.d = d; v.done = done; v.rst = rst;
    v.e_state = es; v.e_start = est; v.e_rv = erv; v.e_tid = etid; v.e_data = edata;
    vecs.push_back(v);
  endfunction

  logic [15:0] addr_pool [14] = '{16'h100, 16'h110, 16'h118, 16'h118, 16'h118, 16'h120,
                                  16'h128, 16'h130, 16'h138, 16'h150, 16'h158, 16'h160,
                                  16'h124, 16'h010};
  logic [31:0] ctl_pool [8] = '{32'h1, 32'h3, 32'h1, 32'h3, 32'h7, 32'h0, 32'h5, 32'h3};

  initial begin
    reset                 = 1'b1;
    acc_done              = 1'b0;
    mmio_if.mmio_wr_valid = 1'b0;
    mmio_if.mmio_rd_valid = 1'b0;
    mmio_if.addr          = '0;
    mmio_if.tid           = '0;
    mmio_if.data          = '0;
    modelReset();

    //      wr    rd    byte     tid    data                      done  rst   state  start rv    tid    rdata
    addVec(1'b0, 1'b0, 16'h000, 9'd0,  64'h0,                    1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 9'd0,  64'h0);
    addVec(1'b0, 1'b1, 16'h100, 9'd5,  64'h0,                    1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 9'd5,  64'h0);
    addVec(1'b1, 1'b0, 16'h150, 9'd0,  64'hDEAD_BEEF_0000_1000,  1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 9'd0,  64'h0);
    addVec(1'b1, 1'b0, 16'h158, 9'd0,  64'hFFFF_FFFF_0000_4000,  1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 9'd0,  64'h0);
    addVec(1'b1, 1'b0, 16'h160, 9'd0,  64'h1111,                 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 9'd0,  64'h0);
    addVec(1'b1, 1'b0, 16'h010, 9'd0,  64'h2222,                 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 9'd0,  64'h0);
    addVec(1'b1, 1'b0, 16'h118, 9'd0,  64'h3,                    1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 9'd0,  64'h0);
    addVec(1'b1, 1'b0, 16'h118, 9'd0,  64'h1,                    1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 9'd0,  64'h0);
    addVec(1'b1, 1'b0, 16'h118, 9'd0,  64'h3,                    1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 9'd0,  64'h0);
    addVec(1'b0, 1'b0, 16'h000, 9'd0,  64'h0,                    1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 9'd0,  64'h0);
    addVec(1'b0, 1'b0, 16'h000, 9'd0,  64'h0,                    1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 9'd0,  64'h0);
    addVec(1'b0, 1'b1, 16'h100, 9'd7,  64'h0,                    1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 9'd7,  64'h0B);
    addVec(1'b1, 1'b0, 16'h118, 9'd0,  64'h7,                    1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 9'd0,  64'h0);
    addVec(1'b0, 1'b1, 16'h100, 9'd8,  64'h0,                    1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 9'd8,  64'h0C);
    addVec(1'b1, 1'b0, 16'h118, 9'd0,  64'h1,                    1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 9'd0,  64'h0);
    addVec(1'b1, 1'b0, 16'h118, 9'd0,  64'h3,                    1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 9'd0,  64'h0);
    addVec(1'b0, 1'b1, 16'h100, 9'd9,  64'h0,                    1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 9'd9,  64'h02);
    addVec(1'b1, 1'b0, 16'h118, 9'd0,  64'h5,                    1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 9'd0,  64'h0);
    addVec(1'b1, 1'b0, 16'h118, 9'd0,  64'h0,                    1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 9'd0,  64'h0);
    addVec(1'b1, 1'b0, 16'h110, 9'd0,  64'h1234,                 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 9'd0,  64'h0);
    addVec(1'b1, 1'b1, 16'h110, 9'd6,  64'h5678,                 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 9'd6,  RB ? 64'h1234 : 64'h0);
    addVec(1'b0, 1'b1, 16'h100, 9'd1,  64'h0,                    1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 9'd1,  64'h0);
    addVec(1'b0, 1'b1, 16'h110, 9'd2,  64'h0,                    1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 9'd2,  RB ? 64'h5678 : 64'h0);
    addVec(1'b0, 1'b1, 16'h150, 9'd3,  64'h0,                    1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 9'd3,  RB ? 64'hDEAD_BEEF_0000_1000 : 64'h0);
    addVec(1'b0, 1'b1, 16'h300, 9'd4,  64'h0,                    1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 9'd4,  64'h0);
    addVec(1'b1, 1'b0, 16'h118, 9'd0,  64'h1,                    1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 9'd0,  64'h0);
    addVec(1'b1, 1'b0, 16'h118, 9'd0,  64'h3,                    1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 9'd0,  64'h0);
    addVec(1'b1, 1'b0, 16'h118, 9'd0,  64'h7,                    1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 9'd0,  64'h0);
    addVec(1'b0, 1'b1, 16'h100, 9'd10, 64'h0,                    1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 9'd10, 64'h0C);
    addVec(1'b1, 1'b0, 16'h118, 9'd0,  64'h1,                    1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 9'd0,  64'h0);
    addVec(1'b1, 1'b0, 16'h118, 9'd0,  64'h3,                    1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 9'd0,  64'h0);
    addVec(1'b0, 1'b1, 16'h100, 9'd11, 64'h0,                    1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 9'd0,  64'h0);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].wr, vecs[k].rd, vecs[k].b, vecs[k].tid, vecs[k].d,
                    vecs[k].done, vecs[k].rst);
      checkOutput($sformatf("v%0d_state", k), 64'(state), 64'(vecs[k].e_state));
      checkOutput($sformatf("v%0d_start", k), 64'(acc_start), 64'(vecs[k].e_start));
      checkOutput($sformatf("v%0d_rsp_valid", k), 64'(mmio_if.rsp_valid), 64'(vecs[k].e_rv));
      if (vecs[k].e_rv) begin
        checkOutput($sformatf("v%0d_rsp_tid", k), 64'(mmio_if.rsp_tid), 64'(vecs[k].e_tid));
        checkOutput($sformatf("v%0d_rsp_data", k), mmio_if.rsp_data, vecs[k].e_data);
      end
      checkRegs($sformatf("v%0d", k));
    end

    for (int n = 0; n < 400; n++) begin
      bit          wr, rd, dn, rs;
      logic [15:0] b;
      logic [63:0] d;
      wr = ($urandom_range(9) < 5);
      rd = ($urandom_range(9) < 4);
      dn = ($urandom_range(9) < 2);
      rs = ($urandom_range(99) < 2);
      b  = addr_pool[$urandom_range(13)];
      if (b == 16'h118) d = {$urandom, ctl_pool[$urandom_range(7)]};
      else              d = {$urandom, $urandom};
      applyStimulus(wr, rd, b, 9'($urandom), d, dn, rs);
      checkModel($sformatf("r%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
